// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin scheduler sharing one tx_top UART transmitter among NUM_REQ requesters.
// A byte is captured on the req handshake, strobed into tx_top, and the frame is tracked through busy_reg.
module tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT = 16,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_par_en,
  input  logic [NUM_REQ-1:0]            req_par_typ,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          busy_reg,
  output logic [DATA_WIDTH-1:0]         p_data,
  output logic                          par_en,
  output logic                          par_typ,
  output logic                          data_valid,
  output logic [IW-1:0]                 grant_id,
  output logic                          active,
  output logic                          to_err
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         grant_id_q, grant_id_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  data_valid_q, data_valid_d;
  logic                  active_q, active_d;
  logic                  to_err_q, to_err_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]         win;
  logic                  any_valid;
  logic                  grant;
  // Search downward so the requester closest to rr_ptr overwrites the others and wins.
  always_comb begin
    win = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[IW'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
        win = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
        any_valid = 1'b1;
      end
    end
    grant = state_q == IDLE && !busy_reg && any_valid;
    req_ready = {{(NUM_REQ-1){1'b0}}, grant} << win;
  end
  // The timeout fires as the counter reaches TIMEOUT-1, so to_err lands TIMEOUT cycles after LOAD.
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_id_d = grant_id_q;
    p_data_d = p_data_q;
    par_en_d = par_en_q;
    par_typ_d = par_typ_q;
    cnt_d = '0;
    cnt_inc = cnt_q + 1'b1;
    to_err_d = 1'b0;
    case (state_q)
      IDLE: if (grant) begin
        state_d = LOAD;
        grant_id_d = win;
        p_data_d = req_data[win*DATA_WIDTH +: DATA_WIDTH];
        par_en_d = req_par_en[win];
        par_typ_d = req_par_typ[win];
        rr_ptr_d = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
      LOAD: state_d = WAIT_BUSY;
      WAIT_BUSY: if (busy_reg) state_d = WAIT_DONE;
        else if (cnt_inc == CW'(TIMEOUT - 1)) begin
          to_err_d = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_inc;
      WAIT_DONE: state_d = busy_reg ? WAIT_DONE : IDLE;
      default: state_d = IDLE;
    endcase
    data_valid_d = state_d == LOAD;
    active_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_id_q <= '0;
      p_data_q <= '0;
      par_en_q <= 1'b0;
      par_typ_q <= 1'b0;
      data_valid_q <= 1'b0;
      active_q <= 1'b0;
      to_err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      p_data_q <= p_data_d;
      par_en_q <= par_en_d;
      par_typ_q <= par_typ_d;
      data_valid_q <= data_valid_d;
      active_q <= active_d;
      to_err_q <= to_err_d;
      cnt_q <= cnt_d;
    end
  end
  assign p_data = p_data_q;
  assign par_en = par_en_q;
  assign par_typ = par_typ_q;
  assign data_valid = data_valid_q;
  assign grant_id = grant_id_q;
  assign active = active_q;
  assign to_err = to_err_q;
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: scoreboard bench for tx_arbiter with a small tx_top busy model.
module tb_tx_arbiter;
  localparam int N = 4, W = 8, TO = 16, FRAME = 11;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_par_en = '0, req_par_typ = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic busy_reg, busy_auto, busy_man = 1'b0, auto_en = 1'b1;
  logic [W-1:0] p_data;
  logic par_en, par_typ, data_valid, active, to_err;
  logic [1:0] grant_id;
  int fcnt;
  int checks = 0, fails = 0;
  typedef struct packed {logic [1:0] id; logic [7:0] d; logic pe; logic pt;} exp_t;
  exp_t sb[$];

  tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_par_en), .req_par_typ(req_par_typ), .req_ready(req_ready),
    .busy_reg(busy_reg), .p_data(p_data), .par_en(par_en), .par_typ(par_typ),
    .data_valid(data_valid), .grant_id(grant_id), .active(active), .to_err(to_err)
  );

  always #5 clk = ~clk;
  assign busy_reg = auto_en ? busy_auto : busy_man;

  // tx_top stand-in: busy rises the cycle after data_valid and stays high for FRAME cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_auto <= 1'b0;
      fcnt <= 0;
    end else if (data_valid) begin
      busy_auto <= 1'b1;
      fcnt <= FRAME;
    end else if (fcnt > 1) fcnt <= fcnt - 1;
    else if (fcnt == 1) begin
      fcnt <= 0;
      busy_auto <= 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    auto_en = 1'b1;
    busy_man = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic get_exp(output exp_t e);
    if (sb.size() == 0) e = 'x;
    else e = sb.pop_front();
  endtask

  task automatic wait_dv(output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (data_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (active === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({data_valid, active, to_err, par_en, par_typ} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got dv/act/err/pe/pt=%b, expected 00000", {data_valid, active, to_err, par_en, par_typ});
    end
    checks++;
    if (p_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_p_data: got %h, expected 00", p_data);
    end
    checks++;
    if (grant_id !== 2'd0) begin
      fails++;
      $display("FAIL reset_grant_id: got %0d, expected 0", grant_id);
    end
    checks++;
    if (req_ready !== 4'b0) begin
      fails++;
      $display("FAIL reset_req_ready: got %b, expected 0000", req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, active} !== 5'b0) begin
      fails++;
      $display("FAIL post_reset_idle: got ready=%b active=%b, expected 0000/0", req_ready, active);
    end
  endtask

  task automatic test_single;
    exp_t e;
    bit ok;
    int n, fall, act;
    bit seen;
    do_reset();
    req_data[7:0] = 8'hAE;
    req_par_en = 4'b0001;
    req_par_typ = 4'b0001;
    req_valid = 4'b0001;
    sb.push_back('{2'd0, 8'hAE, 1'b1, 1'b1});
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL single_ready: got %b, expected 0001", req_ready);
    end
    wait_dv(ok, n);
    get_exp(e);
    checks++;
    if (!ok || n != 1 || {grant_id, p_data, par_en, par_typ} !== e) begin
      fails++;
      $display("FAIL single_load: got id=%0d data=%h pe=%b pt=%b after %0d cycles (seen %b), expected id=%0d data=%h pe=%b pt=%b after 1",
               grant_id, p_data, par_en, par_typ, n, ok, e.id, e.d, e.pe, e.pt);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL single_ready_one_cycle: got %b in LOAD, expected 0000", req_ready);
    end
    req_valid = '0;
    seen = 1'b0;
    fall = -1;
    act = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy_reg) seen = 1'b1;
      else if (seen && fall < 0) fall = i;
      if (!active) begin
        act = i;
        break;
      end
    end
    checks++;
    if (!seen || act != fall + 1) begin
      fails++;
      $display("FAIL single_active_end: active fell at %0d, busy fell at %0d (busy seen %b), expected active one cycle after busy",
               act, fall, seen);
    end
  endtask

  task automatic test_round_robin;
    exp_t e;
    bit ok;
    int n;
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] pe = 4'b1010, pt = 4'b0110;
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = bytes[i];
    req_par_en = pe;
    req_par_typ = pt;
    for (int k = 0; k < 5; k++) sb.push_back('{2'(k % 4), bytes[k % 4], pe[k % 4], pt[k % 4]});
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_dv(ok, n);
      get_exp(e);
      checks++;
      if (!ok || {grant_id, p_data, par_en, par_typ} !== e) begin
        fails++;
        $display("FAIL rr_grant%0d: got id=%0d data=%h pe=%b pt=%b (seen %b), expected id=%0d data=%h pe=%b pt=%b",
                 k, grant_id, p_data, par_en, par_typ, ok, e.id, e.d, e.pe, e.pt);
      end
      if (k > 0) begin
        checks++;
        if (n != FRAME + 3) begin
          fails++;
          $display("FAIL rr_spacing%0d: got %0d cycles between strobes, expected %0d", k, n, FRAME + 3);
        end
      end
    end
    req_valid = '0;
    wait_idle(ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      fails++;
      $display("FAIL rr_drain: idle reached %b, leftover expectations %0d, expected 1/0", ok, sb.size());
    end
  endtask

  task automatic test_busy_idle;
    exp_t e;
    bit ok;
    int n;
    do_reset();
    auto_en = 1'b0;
    busy_man = 1'b1;
    req_data[23:16] = 8'h5A;
    req_par_en = 4'b0100;
    req_par_typ = 4'b0000;
    req_valid = 4'b0100;
    sb.push_back('{2'd2, 8'h5A, 1'b1, 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || active !== 1'b0) begin
        fails++;
        $display("FAIL busy_block%0d: got ready=%b active=%b, expected 0000/0", i, req_ready, active);
      end
    end
    busy_man = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL busy_release_ready: got %b, expected 0100", req_ready);
    end
    wait_dv(ok, n);
    get_exp(e);
    checks++;
    if (!ok || {grant_id, p_data, par_en, par_typ} !== e) begin
      fails++;
      $display("FAIL busy_grant: got id=%0d data=%h pe=%b pt=%b (seen %b), expected id=%0d data=%h pe=%b pt=%b",
               grant_id, p_data, par_en, par_typ, ok, e.id, e.d, e.pe, e.pt);
    end
    req_valid = '0;
    busy_man = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (active !== 1'b1 || to_err !== 1'b0) begin
      fails++;
      $display("FAIL busy_hold_active: got active=%b to_err=%b, expected 1/0", active, to_err);
    end
    busy_man = 1'b0;
    @(negedge clk);
    checks++;
    if (active !== 1'b0) begin
      fails++;
      $display("FAIL busy_fall_idle: got active=%b one cycle after fall, expected 0", active);
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    bit ok;
    int n, m;
    do_reset();
    auto_en = 1'b0;
    busy_man = 1'b0;
    req_data[7:0] = 8'hC3;
    req_data[15:8] = 8'h3C;
    req_par_en = 4'b0010;
    req_par_typ = 4'b0001;
    req_valid = 4'b0011;
    sb.push_back('{2'd0, 8'hC3, 1'b0, 1'b1});
    sb.push_back('{2'd1, 8'h3C, 1'b1, 1'b0});
    wait_dv(ok, n);
    get_exp(e);
    checks++;
    if (!ok || {grant_id, p_data, par_en, par_typ} !== e) begin
      fails++;
      $display("FAIL to_first_grant: got id=%0d data=%h (seen %b), expected id=%0d data=%h", grant_id, p_data, ok, e.id, e.d);
    end
    m = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      m++;
      if (to_err === 1'b1) break;
    end
    checks++;
    if (m != TO || to_err !== 1'b1) begin
      fails++;
      $display("FAIL to_delay: to_err=%b after %0d cycles from LOAD, expected 1 after %0d", to_err, m, TO);
    end
    checks++;
    if (active !== 1'b0) begin
      fails++;
      $display("FAIL to_idle: got active=%b with to_err, expected 0", active);
    end
    wait_dv(ok, n);
    get_exp(e);
    checks++;
    if (!ok || n != 1 || to_err !== 1'b0 || {grant_id, p_data, par_en, par_typ} !== e) begin
      fails++;
      $display("FAIL to_next_grant: got id=%0d data=%h after %0d cycles to_err=%b (seen %b), expected id=%0d data=%h after 1 to_err=0",
               grant_id, p_data, n, to_err, ok, e.id, e.d);
    end
    req_valid = '0;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL to_second_drop: active=%b never returned to 0", active);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit ok;
    int n;
    do_reset();
    req_data[15:8] = 8'h77;
    req_par_en = 4'b0010;
    req_par_typ = 4'b0010;
    req_valid = 4'b0010;
    sb.push_back('{2'd1, 8'h77, 1'b1, 1'b1});
    wait_dv(ok, n);
    get_exp(e);
    checks++;
    if (!ok || {grant_id, p_data, par_en, par_typ} !== e) begin
      fails++;
      $display("FAIL rstmid_grant: got id=%0d data=%h (seen %b), expected id=%0d data=%h", grant_id, p_data, ok, e.id, e.d);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (active !== 1'b1 || busy_reg !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_in_frame: got active=%b busy=%b, expected 1/1", active, busy_reg);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({p_data, grant_id, par_en, par_typ, data_valid, active, to_err} !== 15'b0) begin
      fails++;
      $display("FAIL rstmid_async_clear: got data=%h id=%0d pe=%b pt=%b dv=%b act=%b err=%b, expected all 0",
               p_data, grant_id, par_en, par_typ, data_valid, active, to_err);
    end
    @(negedge clk);
    rst = 1'b0;
    req_data[15:8] = 8'h88;
    req_data[23:16] = 8'h99;
    req_par_en = 4'b0100;
    req_par_typ = 4'b0010;
    req_valid = 4'b0110;
    sb.push_back('{2'd1, 8'h88, 1'b0, 1'b1});
    wait_dv(ok, n);
    get_exp(e);
    checks++;
    if (!ok || {grant_id, p_data, par_en, par_typ} !== e) begin
      fails++;
      $display("FAIL rstmid_rr_restart: got id=%0d data=%h pe=%b pt=%b (seen %b), expected id=%0d data=%h pe=%b pt=%b",
               grant_id, p_data, par_en, par_typ, ok, e.id, e.d, e.pe, e.pt);
    end
    req_valid = '0;
    wait_idle(ok);
  endtask

  task automatic test_hold_data;
    exp_t e;
    bit ok;
    int n, bad;
    do_reset();
    req_data[15:8] = 8'hEE;
    req_par_en = 4'b0010;
    req_par_typ = 4'b0000;
    req_valid = 4'b0010;
    sb.push_back('{2'd1, 8'hEE, 1'b1, 1'b0});
    wait_dv(ok, n);
    get_exp(e);
    checks++;
    if (!ok || {grant_id, p_data, par_en, par_typ} !== e) begin
      fails++;
      $display("FAIL hold_first: got id=%0d data=%h (seen %b), expected id=%0d data=%h", grant_id, p_data, ok, e.id, e.d);
    end
    req_valid = '0;
    req_data[15:8] = 8'h55;
    bad = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!active) begin
        ok = 1'b1;
        break;
      end
      if (p_data !== 8'hEE) bad++;
    end
    checks++;
    if (!ok || bad != 0) begin
      fails++;
      $display("FAIL hold_active: %0d cycles with p_data not EE (idle reached %b), expected 0", bad, ok);
    end
    @(negedge clk);
    checks++;
    if (p_data !== 8'hEE) begin
      fails++;
      $display("FAIL hold_idle: got p_data=%h before next grant, expected EE", p_data);
    end
    req_valid = 4'b0010;
    sb.push_back('{2'd1, 8'h55, 1'b1, 1'b0});
    wait_dv(ok, n);
    get_exp(e);
    checks++;
    if (!ok || {grant_id, p_data, par_en, par_typ} !== e) begin
      fails++;
      $display("FAIL hold_next_grant: got id=%0d data=%h (seen %b), expected id=%0d data=%h", grant_id, p_data, ok, e.id, e.d);
    end
    req_valid = '0;
    wait_idle(ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_idle();
    test_timeout();
    test_reset_mid();
    test_hold_data();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
